anticoinc_axil_regs: RTL



---
 rtl/anticoinc_pkg.sv | 45 ++++
 rtl/anticoinc_core.sv | 42 ++++
 rtl/anticoinc_axil_regs.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/anticoinc_pkg.sv
// Shared register map, response codes and trigger configuration type for the anticoincidence block.
// ANTICOINC_TRIG_COUNT_EN adds the trigger counter register to the map.
package anticoinc_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned MASK_W   = 32;
  localparam int unsigned WINDOW_W = 16;

  localparam int unsigned REG_CTRL       = 0;
  localparam int unsigned REG_COINC_MASK = 1;
  localparam int unsigned REG_ANTI_MASK  = 2;
  localparam int unsigned REG_WINDOW     = 3;
  localparam int unsigned REG_TRIGCNT    = 4;

  localparam int unsigned NUM_CFG_REGS = 4;
`ifdef ANTICOINC_TRIG_COUNT_EN
  localparam int unsigned NUM_REGS = 5;
`else
  localparam int unsigned NUM_REGS = 4;
`endif

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic                enable;
    logic [MASK_W-1:0]   coinc_mask;
    logic [MASK_W-1:0]   anti_mask;
    logic [WINDOW_W-1:0] window;
  } anticoinc_cfg_t;

  // Merge write data into the current word, one byte lane per strobe bit.
  function automatic logic [DATA_W-1:0] apply_strb(input logic [DATA_W-1:0] cur,
                                                   input logic [DATA_W-1:0] data,
                                                   input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = cur;
    for (int b = 0; b < int'(STRB_W); b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/anticoinc_core.sv
// Anticoincidence trigger: rising-edge coincidence detect, vetoed by the anti mask
// and by a post-veto hold-off window counted in clock cycles.
module anticoinc_core
  import anticoinc_pkg::*;
#(
  parameter int unsigned N_TRIG = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  anticoinc_cfg_t    cfg,
  input  logic [N_TRIG-1:0] trig_in,
  output logic              trig_out
);

  logic [MASK_W-1:0]   trig_ext;
  logic                coinc_c;
  logic                veto_c;
  logic                coinc_prev_q;
  logic [WINDOW_W-1:0] veto_cnt_q;

  // Mask bits above N_TRIG meet zero-extended inputs and so never fire.
  assign trig_ext = MASK_W'(trig_in);
  assign coinc_c  = |(trig_ext & cfg.coinc_mask);
  assign veto_c   = |(trig_ext & cfg.anti_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coinc_prev_q <= 1'b0;
      veto_cnt_q   <= '0;
      trig_out     <= 1'b0;
    end else begin
      coinc_prev_q <= coinc_c;
      if (veto_c) begin
        veto_cnt_q <= cfg.window;
      end else if (veto_cnt_q != '0) begin
        veto_cnt_q <= veto_cnt_q - WINDOW_W'(1);
      end
      trig_out <= cfg.enable & coinc_c & ~coinc_prev_q & ~veto_c & (veto_cnt_q == '0);
    end
  end

endmodule

// File: rtl/anticoinc_axil_regs.sv
// AXI4-Lite register bank (CTRL, COINC_MASK, ANTI_MASK, WINDOW) driving anticoinc_core.
// Define ANTICOINC_TRIG_COUNT_EN for the read-only trigger counter at 0x10 (write clears).
module anticoinc_axil_regs
  import anticoinc_pkg::*;
#(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned N_TRIG             = 16
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic [N_TRIG-1:0]                 trig_in,
  output logic                              trig_out
);

  localparam int unsigned IDX_W = 3;

  if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
    $error("anticoinc_axil_regs: C_S_AXI_DATA_WIDTH must be 32");
  end
  if (C_S_AXI_ADDR_WIDTH < 5) begin : g_bad_addr_width
    $error("anticoinc_axil_regs: C_S_AXI_ADDR_WIDTH must be at least 5");
  end
  if (N_TRIG < 1 || N_TRIG > 32) begin : g_bad_n_trig
    $error("anticoinc_axil_regs: N_TRIG must be 1..32");
  end

  logic                awready_q;
  logic                bvalid_q;
  logic [1:0]          bresp_q;
  logic                arready_q;
  logic                rvalid_q;
  logic [1:0]          rresp_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   regs_q [NUM_CFG_REGS];
  logic [DATA_W-1:0]   rd_data_c;
  logic [IDX_W-1:0]    wr_idx_c;
  logic [IDX_W-1:0]    rd_idx_c;
  logic                wr_ok_c;
  logic                rd_ok_c;
  anticoinc_cfg_t      cfg_c;
  logic                unused_c;

  // Only ADDR[4:2] decodes: low bits are ignored and upper bits alias.
  assign wr_idx_c = S_AXI_AWADDR[4:2];
  assign rd_idx_c = S_AXI_ARADDR[4:2];
  assign wr_ok_c  = wr_idx_c < IDX_W'(NUM_REGS);
  assign rd_ok_c  = rd_idx_c < IDX_W'(NUM_REGS);
  assign unused_c = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

  // Write channel: AW and W are taken together, one outstanding response at a time.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      for (int i = 0; i < int'(NUM_CFG_REGS); i++) regs_q[i] <= '0;
    end else begin
      awready_q <= ~awready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
      if (awready_q) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok_c ? RESP_OKAY : RESP_SLVERR;
        if (wr_idx_c < IDX_W'(NUM_CFG_REGS)) begin
          regs_q[wr_idx_c[1:0]] <= apply_strb(regs_q[wr_idx_c[1:0]], S_AXI_WDATA, S_AXI_WSTRB);
        end
      end else if (S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

`ifdef ANTICOINC_TRIG_COUNT_EN
  logic [DATA_W-1:0] trig_cnt_q;

  // Clear wins over a coincident increment.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      trig_cnt_q <= '0;
    end else if (awready_q && wr_idx_c == IDX_W'(REG_TRIGCNT)) begin
      trig_cnt_q <= '0;
    end else if (trig_out) begin
      trig_cnt_q <= trig_cnt_q + DATA_W'(1);
    end
  end
`endif

  always_comb begin
    rd_data_c = '0;
    if (rd_idx_c < IDX_W'(NUM_CFG_REGS)) begin
      rd_data_c = regs_q[rd_idx_c[1:0]];
    end
`ifdef ANTICOINC_TRIG_COUNT_EN
    else if (rd_idx_c == IDX_W'(REG_TRIGCNT)) begin
      rd_data_c = trig_cnt_q;
    end
`endif
  end

  // Read channel: data captured at the address handshake, held until RREADY.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      arready_q <= ~arready_q & S_AXI_ARVALID & ~rvalid_q;
      if (arready_q) begin
        rvalid_q <= 1'b1;
        rresp_q  <= rd_ok_c ? RESP_OKAY : RESP_SLVERR;
        rdata_q  <= rd_data_c;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    cfg_c.enable     = regs_q[2'(REG_CTRL)][0];
    cfg_c.coinc_mask = regs_q[2'(REG_COINC_MASK)];
    cfg_c.anti_mask  = regs_q[2'(REG_ANTI_MASK)];
    cfg_c.window     = regs_q[2'(REG_WINDOW)][WINDOW_W-1:0];
  end

  anticoinc_core #(
    .N_TRIG (N_TRIG)
  ) u_core (
    .clk      (ACLK),
    .rst      (ARESET),
    .cfg      (cfg_c),
    .trig_in  (trig_in),
    .trig_out (trig_out)
  );

endmodule
